// File: rtl/uart_rx_os16.sv
// uart_rx_os16: 16x oversampling UART receiver.
// Moves the asynchronous rx line through a 2-flop synchroniser, finds the start bit,
// samples each bit at its centre (every 16 ticks, the first at tick 8), checks the
// optional parity bit and the stop bit, and presents each byte on a valid/ready port.
//
// Ports:
//   clk         rising-edge system clock
//   reset       asynchronous, active-high reset
//   rx          serial input, idle high
//   RxData      received data word, stable while rx_valid is high
//   rx_valid    a data word is waiting for the consumer
//   rx_ready    consumer accepts the word when rx_valid && rx_ready at a rising edge
//   parity_err  parity mismatch on the word in RxData, qualified by rx_valid
//   frame_err   one-cycle pulse: stop bit sampled low, word discarded
//   overrun_err one-cycle pulse: good frame arrived while the previous word was unread
//   busy        receiver is not idle
module uart_rx_os16 #(
    parameter int unsigned CLK_FREQ   = 50000000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY_EN  = 0,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] RxData,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun_err,
    output logic                 busy
);

    // Clocks per oversampling tick, rounded to nearest, never below 1.
    localparam int unsigned DivRaw = (CLK_FREQ + BAUD * 8) / (BAUD * 16);
    localparam int unsigned Div    = (DivRaw < 1) ? 1 : DivRaw;
    localparam int unsigned CntW   = (Div > 1) ? $clog2(Div) : 1;

    localparam logic [CntW-1:0] TickLast = CntW'(Div - 1);
    localparam logic [3:0]      LastBit  = 4'(DATA_BITS - 1);
    localparam logic            ParEn    = (PARITY_EN != 0);
    localparam logic            ParOdd   = (PARITY_ODD != 0);

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StStart  = 3'd1;
    localparam logic [2:0] StData   = 3'd2;
    localparam logic [2:0] StParity = 3'd3;
    localparam logic [2:0] StStop   = 3'd4;
    localparam logic [2:0] StBreak  = 3'd5;

    logic                 rx_meta_q, rx_sync_q;
    logic [2:0]           state_q, state_d;
    logic [CntW-1:0]      tick_cnt_q, tick_cnt_d;
    logic [3:0]           os_cnt_q, os_cnt_d;
    logic [3:0]           bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_pend_q, par_pend_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 parity_err_q, parity_err_d;
    logic                 frame_err_q, frame_err_d;
    logic                 overrun_err_q, overrun_err_d;
    logic                 tick;
    logic                 frame_done;

    always_comb begin
        state_d       = state_q;
        tick_cnt_d    = tick_cnt_q;
        os_cnt_d      = os_cnt_q;
        bit_cnt_d     = bit_cnt_q;
        shift_d       = shift_q;
        par_pend_d    = par_pend_q;
        rx_data_d     = rx_data_q;
        rx_valid_d    = rx_valid_q;
        parity_err_d  = parity_err_q;
        frame_err_d   = 1'b0;
        overrun_err_d = 1'b0;
        tick          = 1'b0;
        frame_done    = 1'b0;

        // Tick generator only runs while a frame is being timed.
        if (state_q == StStart || state_q == StData ||
            state_q == StParity || state_q == StStop) begin
            if (tick_cnt_q == TickLast) begin
                tick       = 1'b1;
                tick_cnt_d = '0;
            end else begin
                tick_cnt_d = tick_cnt_q + 1'b1;
            end
        end else begin
            tick_cnt_d = '0;
        end

        // Ticks within the current bit; wraps 15 -> 0 on each full-bit sample.
        if (tick) begin
            os_cnt_d = os_cnt_q + 4'd1;
        end

        unique case (state_q)
            StIdle: begin
                os_cnt_d  = '0;
                bit_cnt_d = '0;
                if (!rx_sync_q) begin
                    state_d    = StStart;
                    par_pend_d = 1'b0;
                end
            end
            StStart: begin
                // Mid start bit: a high line here was only a glitch.
                if (tick && os_cnt_q == 4'd7) begin
                    os_cnt_d  = '0;
                    bit_cnt_d = '0;
                    state_d   = rx_sync_q ? StIdle : StData;
                end
            end
            StData: begin
                if (tick && os_cnt_q == 4'd15) begin
                    shift_d = {rx_sync_q, shift_q[DATA_BITS-1:1]};
                    if (bit_cnt_q == LastBit) begin
                        state_d = ParEn ? StParity : StStop;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end
            StParity: begin
                if (tick && os_cnt_q == 4'd15) begin
                    par_pend_d = ((^shift_q) ^ ParOdd) != rx_sync_q;
                    state_d    = StStop;
                end
            end
            StStop: begin
                if (tick && os_cnt_q == 4'd15) begin
                    if (rx_sync_q) begin
                        frame_done = 1'b1;
                        state_d    = StIdle;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = StBreak;
                    end
                end
            end
            StBreak: begin
                // Line must return high before another start can be seen.
                if (rx_sync_q) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Consumer handshake; a same-cycle accept frees the slot for the new word.
        if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end
        if (frame_done) begin
            if (!rx_valid_q || rx_ready) begin
                rx_data_d    = shift_q;
                parity_err_d = ParEn & par_pend_q;
                rx_valid_d   = 1'b1;
            end else begin
                overrun_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta_q     <= 1'b1;
            rx_sync_q     <= 1'b1;
            state_q       <= StIdle;
            tick_cnt_q    <= '0;
            os_cnt_q      <= '0;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            par_pend_q    <= 1'b0;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            parity_err_q  <= 1'b0;
            frame_err_q   <= 1'b0;
            overrun_err_q <= 1'b0;
        end else begin
            rx_meta_q     <= rx;
            rx_sync_q     <= rx_meta_q;
            state_q       <= state_d;
            tick_cnt_q    <= tick_cnt_d;
            os_cnt_q      <= os_cnt_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            par_pend_q    <= par_pend_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            parity_err_q  <= parity_err_d;
            frame_err_q   <= frame_err_d;
            overrun_err_q <= overrun_err_d;
        end
    end

    assign RxData      = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign parity_err  = parity_err_q;
    assign frame_err   = frame_err_q;
    assign overrun_err = overrun_err_q;
    assign busy        = (state_q != StIdle);

endmodule

// File: doc/uart_rx_os16.md
Name: uart_rx_os16

Overview:
- Standalone 16x-oversampling UART receiver; the receive-side counterpart to the existing transmitter path (transmit/TxData).
- Deserialises the asynchronous rx line into parallel bytes.
- Checks start, parity and stop bits.
- Hands each byte to the consumer over a valid/ready interface and flags framing, parity and overrun errors.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz
- BAUD, 115200, line rate; DIV = CLK_FREQ/(BAUD*16) rounded to nearest (27 at defaults), minimum 1
- DATA_BITS, 8, data bits per frame, legal 5..8, LSB first
- PARITY_EN, 0, 1 = one parity bit follows the data bits
- PARITY_ODD, 0, 1 = odd parity, 0 = even (ignored when PARITY_EN=0)

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- rx  input  1  serial line, idle high, asynchronous to clk
- RxData  output  DATA_BITS  received byte; stable while rx_valid=1
- rx_valid  output  1  byte available
- rx_ready  input  1  consumer accepts; transfer occurs when rx_valid && rx_ready at a rising edge
- parity_err  output  DATA_BITS? no: 1  parity mismatch on the byte in RxData; qualified by rx_valid
- frame_err  output  1  one-cycle pulse: stop bit sampled low
- overrun_err  output  1  one-cycle pulse: frame completed while rx_valid still high
- busy  output  1  high in every state except IDLE

Behaviour:
- Reset values (async assert, all outputs): RxData=0, rx_valid=0, parity_err=0, frame_err=0, overrun_err=0, busy=0, FSM=IDLE, counters=0. The synchroniser flops reset to 1.
- rx passes through a 2-flop synchroniser; all logic uses the synchronised value.
- Tick generator: free-running 0..DIV-1 counter; tick=1 on the cycle the count equals DIV-1. The counter is held at 0 in IDLE and restarted on start detection.
- FSM states: IDLE, START, DATA, PARITY, STOP, BREAK.
- IDLE: a synchronised rx=0 moves the FSM to START and clears the tick counter and sample counter.
- START: after 8 ticks (mid-bit), sample rx.
  - rx=1: glitch; return to IDLE, no flags.
  - rx=0: enter DATA.
- DATA: sample every 16 ticks. Shift into a shift register LSB first. After DATA_BITS samples, go to PARITY if PARITY_EN, else STOP.
- PARITY: sample after 16 ticks. The computed parity (XOR of the data bits, inverted if PARITY_ODD) is compared with the sampled bit. The mismatch is stored as pending parity error.
- STOP: sample after 16 ticks.
  - rx=1: frame good; go to IDLE the next cycle. The output register loads in that same cycle (see handshake).
  - rx=0: frame_err pulses one cycle. RxData and rx_valid are unchanged and the byte is discarded. Go to BREAK.
- BREAK: wait for synchronised rx=1, then go to IDLE. No new start is detected while in BREAK.
- Handshake and latency:
  - On a good stop sample with rx_valid=0: RxData, parity_err and rx_valid=1 load on the following clock edge. Latency from stop-bit mid-sample tick to rx_valid is 1 clk.
  - rx_valid stays high, and RxData/parity_err stay stable, until a cycle with rx_ready=1; rx_valid clears at that edge.
  - Good frame completes while rx_valid=1 and rx_ready=0 in the same cycle: overrun_err pulses one cycle, new byte dropped, old byte retained.
  - Frame completes in the same cycle as rx_ready=1: the old byte is consumed, the new byte loads, and rx_valid stays 1 with no overrun.
- Receiver reception continues regardless of rx_valid; there is no back-pressure to the line.
- Reset mid-frame: immediate return to IDLE; the partial byte is lost. After reset deasserts, a low rx is treated as a new start edge.
- rx held low permanently: START is valid, data samples are 0, stop=0, so frame_err pulses. The FSM then stays in BREAK until rx rises.

Test Plan:
- Defaults, send 0xA5 (start, 1,0,1,0,0,1,0,1, stop) at 432 clk/bit → rx_valid rises once, RxData=0xA5, parity_err=0; with rx_ready=1 one cycle later, rx_valid drops.
- rx low pulse of 100 clk (< 8 ticks = 216 clk) from idle → FSM returns to IDLE, rx_valid never asserts, no error flags, busy falls.
- Send 0x3C with stop bit driven 0 → frame_err pulses exactly 1 clk, rx_valid stays 0; FSM holds in BREAK until rx=1, then 0x55 is received correctly.
- PARITY_EN=1, PARITY_ODD=0: send 0x07 with parity bit 1 → RxData=0x07, parity_err=0. Send 0x07 with parity bit 0 → parity_err=1 while rx_valid=1.
- rx_ready=0, send 0x11 then 0x22 back-to-back → RxData remains 0x11, overrun_err pulses once at the end of the second frame; after rx_ready=1, rx_valid=0.
- Assert reset during the 4th data bit of 0xFF, release, then send 0x81 → the partial byte is never presented, all outputs read 0 during reset, next rx_valid delivers RxData=0x81.
